rx_serial: RTL and testbench
============================

Name: rx_serial

Overview:
- Serial-to-parallel receiver; sits directly downstream of tx_serial and consumes its data_o/ena_o pair.
- Samples one bit per clock on which ena_i is high, LSB first, and assembles Width-bit words.
- Presents each completed word on a registered valid/ready output port.
- Detects stalled frames (gap timeout) and output overrun.

Parameters:
- Width, 8, data bits per word; legal range 2..32.
- GapMax, 4, max consecutive ena_i-low cycles tolerated mid-word before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  1  serial bit; connects to tx_serial data_o.
- ena_i  in  1  bit-valid strobe; data_i is sampled only when high; connects to tx_serial ena_o.
- data_o  out  Width  received word, LSB = first bit received.
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  consumer accepts the word when valid_o && ready_i.
- overrun_o  out  1  one-cycle pulse: completed word dropped because the output register was occupied.
- abort_o  out  1  one-cycle pulse: partial word discarded on gap timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, bit_cnt=0, gap_cnt=0, data_o=0, valid_o=0, overrun_o=0, abort_o=0.
  - Reset mid-word discards the partial word and any held output word.
- Shift rule: on every cycle with ena_i=1, shreg <= {data_i, shreg[Width-1:1]}, bit_cnt++, gap_cnt=0.
- Frame length: FrameLen = Width, or Width+1 with the optional feature.
- FSM:
  - IDLE: ena_i=1 shifts in bit 0 and moves to SHIFT with bit_cnt=1. ena_i=0 keeps the state; gap_cnt stays 0.
  - SHIFT, ena_i=1, bit is the FrameLen-th: word complete; bit_cnt=0, gap_cnt=0, go to IDLE.
  - SHIFT, ena_i=1, not the last bit: shift and stay in SHIFT.
  - SHIFT, ena_i=0: gap_cnt++. If GapMax>0 and gap_cnt reaches GapMax, pulse abort_o next cycle, clear shreg/bit_cnt/gap_cnt, go to IDLE.
- Back-to-back frames: a bit arriving the cycle after completion starts a new frame from IDLE with no dead cycle.
- Completion timing: data_o and valid_o update on the clock edge after the edge that samples the last bit (1-cycle latency).
- Completion, output register free (valid_o=0, or valid_o && ready_i in the same cycle): load data_o, valid_o=1.
- Completion, output register occupied (valid_o=1, ready_i=0): new word discarded, data_o unchanged, overrun_o pulses one cycle.
- Handshake:
  - valid_o && ready_i with no completion that cycle: valid_o=0 next cycle; data_o holds its last value.
  - valid_o stays 1 until accepted.
  - ready_i is ignored while valid_o=0.
- Counter widths: bit_cnt is $clog2(Width+2) bits; gap_cnt is $clog2(GapMax+1) bits, saturating.

Optional Feature:
- Macro: RX_SERIAL_PARITY_EN.
- Defined:
  - Frame is Width data bits followed by one even-parity bit.
  - Check: XOR of the data bits and the parity bit must be 0.
  - On mismatch the word is discarded (valid_o/data_o untouched, no overrun) and output parity_err_o (1 bit) pulses one cycle, coincident with when valid_o would have risen.
  - Gap timeout also applies before the parity bit.
- Undefined: parity_err_o port absent; frame is exactly Width bits.

Test Plan:
- Contiguous frame (Width=8): ena_i high 8 cycles, bits of 0xA5 LSB first, ready_i=1 -> data_o=0xA5, valid_o=1 for one cycle, rising one cycle after the 8th bit.
- Gapped frame (GapMax=4): 0x5A with 3 idle cycles between every bit -> data_o=0x5A, abort_o never asserted.
- Timeout: 3 bits, then ena_i low 4 cycles -> abort_o pulses once, valid_o stays 0. Next contiguous 0x3C -> data_o=0x3C.
- Backpressure: ready_i=0, send 0x11 then 0x22 -> data_o=0x11, valid_o stays 1, overrun_o pulses at 0x22 completion. Then ready_i=1 -> valid_o drops next cycle.
- Reset mid-word: 4 bits, rst_ni low 2 cycles, then 0xFF -> data_o=0xFF, no abort_o or overrun_o.
- Parity (RX_SERIAL_PARITY_EN): 0x03 with parity bit 0 -> data_o=0x03. 0x03 with parity bit 1 -> parity_err_o pulse, valid_o stays 0.

Source files
------------

// File: rtl/rx_serial.sv
// -----------------------------------------------------------------------------
// rx_serial : serial-to-parallel receiver (pairs with tx_serial)
//
// Samples data_i on every clock where ena_i is high, LSB first, and assembles
// Width-bit words. A completed word is loaded into a registered valid/ready
// output stage one clock after its last bit is sampled.
//
// Optional feature macro: RX_SERIAL_PARITY_EN
//   When defined, each frame carries one extra even-parity bit after the data
//   bits. A frame with bad parity is dropped and parity_err_o pulses instead.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   data_i       in   serial bit
//   ena_i        in   bit-valid strobe
//   data_o       out  received word (LSB = first bit received)
//   valid_o      out  data_o holds an unconsumed word
//   ready_i      in   consumer accepts when valid_o && ready_i
//   overrun_o    out  pulse: completed word dropped, output stage occupied
//   parity_err_o out  pulse: frame dropped on parity error (macro only)
//   abort_o      out  pulse: partial word discarded on gap timeout
// -----------------------------------------------------------------------------
module rx_serial #(
   parameter int Width  = 8,
   parameter int GapMax = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             data_i,
   input  logic             ena_i,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overrun_o,
`ifdef RX_SERIAL_PARITY_EN
   output logic             parity_err_o,
`endif
   output logic             abort_o
);

`ifdef RX_SERIAL_PARITY_EN
   localparam int FrameLen = Width + 1;
`else
   localparam int FrameLen = Width;
`endif
   localparam int CntW = $clog2(Width + 2);
   // A zero-width counter is illegal, so keep one bit when the timeout is off.
   localparam int GapW = (GapMax > 0) ? $clog2(GapMax + 1) : 1;

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   logic             r_state;
   logic [Width-1:0] r_shreg;
   logic [CntW-1:0]  r_bit_cnt;
   logic [GapW-1:0]  r_gap_cnt;
   logic             r_cmpl;      // word completed on the previous edge
   logic [Width-1:0] r_word;      // word waiting to enter the output stage
   logic             r_abort;
   logic [Width-1:0] r_data;
   logic             r_valid;
   logic             r_overrun;
`ifdef RX_SERIAL_PARITY_EN
   logic             r_par_ok;
   logic             r_parity_err;
`endif

   logic [Width-1:0] w_shifted;
   logic             w_last;
   logic             w_gap_hit;
   logic             w_gap_sat;

   assign w_shifted = {data_i, r_shreg[Width-1:1]};
   assign w_last    = (r_bit_cnt == CntW'(FrameLen - 1));
   // The GapMax-th consecutive idle cycle mid-word triggers the abort.
   assign w_gap_hit = (GapMax > 0) && (r_gap_cnt == GapW'(GapMax - 1));
   assign w_gap_sat = &r_gap_cnt;

   // ---------------------------------------------------------------- framer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_cmpl    <= 1'b0;
         r_word    <= '0;
         r_abort   <= 1'b0;
`ifdef RX_SERIAL_PARITY_EN
         r_par_ok  <= 1'b0;
`endif
      end else begin
         r_cmpl  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ena_i) begin
                  r_shreg   <= w_shifted;
                  r_bit_cnt <= CntW'(1);
                  r_gap_cnt <= '0;
                  r_state   <= SHIFT;
               end
            end
            default: begin
               if (ena_i) begin
                  r_shreg   <= w_shifted;
                  r_gap_cnt <= '0;
                  if (w_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= IDLE;
                     r_cmpl    <= 1'b1;
`ifdef RX_SERIAL_PARITY_EN
                     // data_i is the parity bit; shreg already holds the data
                     r_word    <= r_shreg;
                     r_par_ok  <= ~(^{r_shreg, data_i});
`else
                     r_word    <= w_shifted;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CntW'(1);
                  end
               end else if (w_gap_hit) begin
                  r_abort   <= 1'b1;
                  r_shreg   <= '0;
                  r_bit_cnt <= '0;
                  r_gap_cnt <= '0;
                  r_state   <= IDLE;
               end else if (!w_gap_sat) begin
                  r_gap_cnt <= r_gap_cnt + GapW'(1);
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------- output stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef RX_SERIAL_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_overrun <= 1'b0;
`ifdef RX_SERIAL_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
         if (r_cmpl) begin
`ifdef RX_SERIAL_PARITY_EN
            if (!r_par_ok) begin
               r_parity_err <= 1'b1;
            end else
`endif
            // Register is free if empty or being drained this very cycle.
            if (!r_valid || ready_i) begin
               r_data  <= r_word;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign data_o       = r_data;
   assign valid_o      = r_valid;
   assign overrun_o    = r_overrun;
   assign abort_o      = r_abort;
`ifdef RX_SERIAL_PARITY_EN
   assign parity_err_o = r_parity_err;
`endif

endmodule

// File: tb/tb_rx_serial.sv
module tb_rx_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din;
   logic       ena;
   logic [7:0] dout;
   logic       valid;
   logic       ready;
   logic       overrun;
   logic       abort;
`ifdef RX_SERIAL_PARITY_EN
   logic       perr;
`endif

   rx_serial #(.Width(8), .GapMax(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .data_i       (din),
      .ena_i        (ena),
      .data_o       (dout),
      .valid_o      (valid),
      .ready_i      (ready),
      .overrun_o    (overrun),
`ifdef RX_SERIAL_PARITY_EN
      .parity_err_o (perr),
`endif
      .abort_o      (abort)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int n_abort = 0;
   int n_ovr   = 0;
   int n_perr  = 0;

   // Monitor: collect accepted words and event pulses away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) got_q.push_back(dout);
         if (abort)   n_abort++;
         if (overrun) n_ovr++;
`ifdef RX_SERIAL_PARITY_EN
         if (perr)    n_perr++;
`endif
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive n bits of v LSB first, with gap idle cycles between bits.
   task automatic send_bits(input logic [31:0] v, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         ena = 1'b1;
         din = v[i];
         if (i < n - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1;
               ena = 1'b0;
               din = 1'b0;
            end
         end
      end
      @(posedge clk); #1;
      ena = 1'b0;
      din = 1'b0;
   endtask

   // Send one well-formed word and push the expected output.
   task automatic send_word(input logic [7:0] w, input int gap, input bit expect_out);
`ifdef RX_SERIAL_PARITY_EN
      send_bits({23'd0, ^w, w}, 9, gap);
`else
      send_bits({24'd0, w}, 8, gap);
`endif
      if (expect_out) exp_q.push_back(w);
   endtask

   // Wait (bounded) for outstanding words, then compare the scoreboard.
   task automatic drain(input string name);
      int t = 0;
      while (got_q.size() < exp_q.size() && t < 60) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         if (got_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: missing word, expected %0h", name, e);
         end else begin
            chk(name, {24'd0, got_q.pop_front()}, {24'd0, e});
         end
      end
      n_chk++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d unexpected word(s), first %0h", name, got_q.size(), got_q[0]);
         got_q.delete();
      end
   endtask

   typedef struct {
      logic [7:0] word;
      int         gap;
      logic [7:0] exp_data;
      int         exp_abort;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int a0, o0, p0;
      tbl[0] = '{8'hA5, 0, 8'hA5, 0};
      tbl[1] = '{8'h5A, 3, 8'h5A, 0};
      tbl[2] = '{8'h3C, 1, 8'h3C, 0};
      tbl[3] = '{8'h00, 0, 8'h00, 0};
      tbl[4] = '{8'hFF, 2, 8'hFF, 0};
      tbl[5] = '{8'h81, 3, 8'h81, 0};

      rst_n = 1'b0; din = 1'b0; ena = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",    {24'd0, dout}, 32'd0);
      chk("rst_valid",   {31'd0, valid}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_abort",   {31'd0, abort}, 32'd0);
      rst_n = 1'b1;

      // Latency: valid rises exactly one cycle after the last bit is sampled
      send_word(8'hA5, 0, 1'b1);
      @(negedge clk); chk("lat_pre",  {31'd0, valid}, 32'd0);
      @(negedge clk); chk("lat_up",   {31'd0, valid}, 32'd1);
                      chk("lat_data", {24'd0, dout}, 32'hA5);
      @(negedge clk); chk("lat_down", {31'd0, valid}, 32'd0);
      drain("lat_word");

      // Table-driven frames with ready held high
      foreach (tbl[k]) begin
         a0 = n_abort;
         send_word(tbl[k].word, tbl[k].gap, 1'b0);
         exp_q.push_back(tbl[k].exp_data);
         drain($sformatf("tbl%0d_word", k));
         chk($sformatf("tbl%0d_abort", k), n_abort - a0, tbl[k].exp_abort);
      end

      // Back-to-back frames with no dead cycle between them
      send_bits({16'd0, 8'h93, 8'h6C}, 16, 0);
      exp_q.push_back(8'h6C);
      exp_q.push_back(8'h93);
      drain("b2b");

      // Gap timeout: 3 bits then a long idle
      a0 = n_abort;
      send_bits(32'h5, 3, 0);
      repeat (8) @(posedge clk);
      chk("to_abort", n_abort - a0, 1);
      chk("to_valid", {31'd0, valid}, 32'd0);
      send_word(8'h3C, 0, 1'b1);
      drain("to_next");

      // Backpressure and overrun
      #1;
      ready = 1'b0;
      o0 = n_ovr;
      send_word(8'h11, 0, 1'b1);
      send_word(8'h22, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk("bp_valid",   {31'd0, valid}, 32'd1);
      chk("bp_data",    {24'd0, dout}, 32'h11);
      chk("bp_overrun", n_ovr - o0, 1);
      @(posedge clk); #1;
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("bp_drop", {31'd0, valid}, 32'd0);
      drain("bp_word");

      // Reset in the middle of a word
      a0 = n_abort; o0 = n_ovr;
      send_bits(32'hF, 4, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rm_valid", {31'd0, valid}, 32'd0);
      chk("rm_data",  {24'd0, dout}, 32'd0);
      rst_n = 1'b1;
      send_word(8'hFF, 0, 1'b1);
      drain("rm_word");
      chk("rm_abort",   n_abort - a0, 0);
      chk("rm_overrun", n_ovr - o0, 0);

`ifdef RX_SERIAL_PARITY_EN
      p0 = n_perr;
      send_bits({23'd0, 1'b0, 8'h03}, 9, 0);
      exp_q.push_back(8'h03);
      drain("par_ok");
      chk("par_ok_err", n_perr - p0, 0);
      send_bits({23'd0, 1'b1, 8'h03}, 9, 0);
      drain("par_bad");
      chk("par_bad_err", n_perr - p0, 1);
      chk("par_bad_valid", {31'd0, valid}, 32'd0);
`else
      p0 = n_perr;
      chk("no_perr", n_perr - p0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1, "timeout");
   end

endmodule
